// File: rtl/counter_run_scheduler.sv
// Round-robin scheduler sharing one start/stop counter between requesters.
// Each granted run produces exactly len increments, then reports the count with a done pulse.
module counter_run_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 4,
  parameter int CNT_MAX   = 13
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   req_len,
  input  logic [CNT_WIDTH-1:0]           count,
  output logic                           start,
  output logic                           stop,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic [CNT_WIDTH-1:0]           result,
  output logic                           busy
);

  // state | meaning
  // IDLE  | waiting for any req
  // ARB   | round-robin pick, latch run length
  // START | start pulse to counter
  // RUN   | counting cycles until len-1
  // STOP  | stop pulse, last increment edge
  // DONE  | done pulse, capture count

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (CNT_MAX < 1 || CNT_MAX >= (1 << CNT_WIDTH)) begin : g_bad_cnt_max
    $error("CNT_MAX must fit in CNT_WIDTH bits");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nx;
  logic [PTR_W-1:0]     win_q, win_q_nx;
  logic [CNT_WIDTH-1:0] len_q, len_q_nx;
  logic [CNT_WIDTH-1:0] rc, rc_nx;

  logic                 start_nx, stop_nx, busy_nx;
  logic [NUM_REQ-1:0]   grant_nx, done_nx;
  logic [CNT_WIDTH-1:0] result_nx;

  logic                 found;
  logic [PTR_W-1:0]     win;
  logic [CNT_WIDTH-1:0] win_len;

  // First set request at or above rr_ptr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = rr_ptr;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    win_len = req_len[int'(win)*CNT_WIDTH +: CNT_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      win_q  <= '0;
      len_q  <= '0;
      rc     <= '0;
      start  <= 1'b0;
      stop   <= 1'b0;
      busy   <= 1'b0;
      grant  <= '0;
      done   <= '0;
      result <= '0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_ptr_nx;
      win_q  <= win_q_nx;
      len_q  <= len_q_nx;
      rc     <= rc_nx;
      start  <= start_nx;
      stop   <= stop_nx;
      busy   <= busy_nx;
      grant  <= grant_nx;
      done   <= done_nx;
      result <= result_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (|req) state_nx = S_ARB;
      S_ARB: begin
        if (!found)              state_nx = S_IDLE;
        else if (win_len == '0)  state_nx = S_DONE;
        else                     state_nx = S_START;
      end
      S_START: state_nx = (len_q == CNT_WIDTH'(1)) ? S_STOP : S_RUN;
      S_RUN:   if (rc == len_q - 1'b1) state_nx = S_STOP;
      S_STOP:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    rr_ptr_nx = rr_ptr;
    win_q_nx  = win_q;
    len_q_nx  = len_q;
    rc_nx     = rc;
    grant_nx  = grant;
    result_nx = result;
    case (state)
      S_ARB: begin
        grant_nx = '0;
        if (found) begin
          grant_nx[win] = 1'b1;
          win_q_nx      = win;
          len_q_nx      = win_len;
        end
      end
      S_START: rc_nx = CNT_WIDTH'(1);
      S_RUN:   rc_nx = rc + 1'b1;
      S_DONE: begin
        grant_nx  = '0;
        result_nx = count;
        if (int'(win_q) == NUM_REQ - 1) rr_ptr_nx = '0;
        else                            rr_ptr_nx = win_q + 1'b1;
      end
      default: ;
    endcase
    start_nx = (state_nx == S_START);
    stop_nx  = (state_nx == S_STOP);
    busy_nx  = (state_nx != S_IDLE);
    done_nx  = (state_nx == S_DONE) ? grant_nx : '0;
  end

endmodule

// File: tb/tb_counter_run_scheduler.sv
// Directed bench for counter_run_scheduler with a behavioural start/stop counter model.
// Expected values are hand-computed from the run lengths and starting counts.
module tb_counter_run_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  count;
  logic        start, stop, busy;
  logic [3:0]  grant, done, result;

  logic        load_en;
  logic [3:0]  load_val;
  logic        cnt_en;
  int          n_inc, n_start, n_stop, overlap, multi, cyc;
  int          start_cyc, stop_cyc;
  int          n_chk, n_pass;

  counter_run_scheduler #(.NUM_REQ(4), .CNT_WIDTH(4), .CNT_MAX(13)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_len (req_len),
    .count   (count),
    .start   (start),
    .stop    (stop),
    .grant   (grant),
    .done    (done),
    .result  (result),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter the scheduler drives: enable rises after start, clears after stop, wraps 13 -> 0.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      count  <= '0;
      cnt_en <= 1'b0;
    end else if (load_en) begin
      count <= load_val;
    end else begin
      if (cnt_en) begin
        count <= (count == 4'd13) ? 4'd0 : count + 4'd1;
        n_inc <= n_inc + 1;
      end
      if (start) cnt_en <= 1'b1;
      if (stop)  cnt_en <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (start) begin n_start++; start_cyc = cyc; end
    if (stop)  begin n_stop++;  stop_cyc  = cyc; end
    if (start && stop) overlap++;
    if ($countones(grant) > 1 || $countones(done) > 1) multi++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic wait_done(output logic [3:0] d);
    bit seen;
    seen = 1'b0;
    d    = '0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done != '0) begin
        d    = done;
        seen = 1'b1;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_count(input logic [3:0] v);
    @(negedge clk);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  logic [3:0] d;
  logic [3:0] exp_rr [5];
  int         c0, inc0, st0, sp0;

  initial begin
    cyc = 0; n_inc = 0; n_start = 0; n_stop = 0; overlap = 0; multi = 0;
    n_chk = 0; n_pass = 0; start_cyc = 0; stop_cyc = 0;
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset    = 1'b0;
    req      = 4'b1111;
    req_len  = 16'h1111;
    load_en  = 1'b0;
    load_val = '0;

    // Reset held with all requests up
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outs", {17'd0, start, stop, grant, done, busy, result}, 32'd0);
    end

    // Round robin, all len=1
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_done(d);
      if (k == 4) req = 4'b0000;
      chk($sformatf("rr_done_%0d", k), {28'd0, d}, {28'd0, exp_rr[k]});
    end
    chk("rr_no_overlap", overlap, 0);
    chk("rr_onehot", multi, 0);

    // Single run, len0=5 from count 0
    load_count(4'd0);
    inc0    = n_inc;
    req_len = 16'h0005;
    req     = 4'b0001;
    c0      = cyc;
    wait_done(d);
    req = 4'b0000;
    chk("single_done", {28'd0, d}, 32'h1);
    chk("single_start_cyc", start_cyc - c0, 2);
    chk("single_stop_cyc", stop_cyc - c0, 7);
    @(negedge clk);
    chk("single_result", {28'd0, result}, 32'd5);
    chk("single_incs", n_inc - inc0, 5);
    repeat (3) @(negedge clk);
    chk("single_result_held", {28'd0, result}, 32'd5);
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Wrap: 12 + 4 -> 2
    load_count(4'd12);
    inc0    = n_inc;
    req_len = 16'h0004;
    req     = 4'b0001;
    wait_done(d);
    req = 4'b0000;
    chk("wrap_done", {28'd0, d}, 32'h1);
    @(negedge clk);
    chk("wrap_result", {28'd0, result}, 32'd2);
    chk("wrap_incs", n_inc - inc0, 4);

    // Zero length on requester 2, count stays 2
    st0     = n_start;
    sp0     = n_stop;
    inc0    = n_inc;
    req_len = 16'h0000;
    req     = 4'b0100;
    wait_done(d);
    req = 4'b0000;
    chk("zero_done", {28'd0, d}, 32'h4);
    @(negedge clk);
    chk("zero_result", {28'd0, result}, 32'd2);
    chk("zero_no_start", n_start - st0, 0);
    chk("zero_no_stop", n_stop - sp0, 0);
    chk("zero_incs", n_inc - inc0, 0);

    // len 15 > CNT_MAX on requester 3: (2 + 15) mod 14 = 3
    inc0    = n_inc;
    req_len = 16'hF000;
    req     = 4'b1000;
    wait_done(d);
    req = 4'b0000;
    chk("long_done", {28'd0, d}, 32'h8);
    @(negedge clk);
    chk("long_result", {28'd0, result}, 32'd3);
    chk("long_incs", n_inc - inc0, 15);

    // Reset in the middle of a len=9 run
    req_len = 16'h0009;
    req     = 4'b0001;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (start) seen = 1'b1;
      end
      if (!seen) chk("midrst_start_timeout", 32'd0, 32'd1);
    end
    repeat (3) @(negedge clk);
    chk("midrst_busy_before", {31'd0, busy}, 32'd1);
    sp0   = n_stop;
    reset = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    chk("midrst_outs", {19'd0, start, stop, grant, done, busy}, 32'd0);
    chk("midrst_result", {28'd0, result}, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_stop", n_stop - sp0, 0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    chk("final_no_overlap", overlap, 0);
    chk("final_onehot", multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
